// File: rtl/pseudo_spi_rx_sram_writer_if.sv
// Serial receive pins plus the low-active SRAM write port of the pseudo-SPI receiver.
// master = receiver side, slave = transmitter/SRAM side.
interface pseudo_spi_rx_sram_writer_if #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10
);
    logic                         SCLK1;
    logic                         SCLK2;
    logic                         LAT;
    logic                         SPI_SI;
    logic                         CEN;
    logic                         WEN;
    logic [MEMORY_ADDR_WIDTH-1:0] A;
    logic [MEMORY_DATA_WIDTH-1:0] D;

    modport master (
        input  SCLK1, SCLK2, LAT, SPI_SI,
        output CEN, WEN, A, D
    );

    modport slave (
        output SCLK1, SCLK2, LAT, SPI_SI,
        input  CEN, WEN, A, D
    );
endinterface

// File: rtl/pseudo_spi_rx_sram_writer.sv
// Pseudo-SPI receiver: synchronises the two-phase serial stream, deserialises
// MSB-first bytes and writes each one into the shared SRAM with a single CEN/WEN cycle.
module pseudo_spi_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise
);
    logic [STAGES-1:0] sr;

    // lvl is the final stage delayed once so it lines up with the registered rise pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            lvl  <= sr[STAGES-1];
            rise <= sr[STAGES-1] & ~lvl;
        end
    end
endmodule

module pseudo_spi_rx_sram_writer #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int RESERVED_DATA_LEN = 8,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    pseudo_spi_rx_sram_writer_if.master  bus,
    output logic                         RX_MUX,
    output logic [RESERVED_DATA_LEN-1:0] BYTE_CNT,
    output logic                         RX_DONE,
    output logic                         RX_ERR
);
    localparam int NUM_LANES = 4;
    localparam int BW        = $clog2(MEMORY_DATA_WIDTH + 1);
    localparam int L_S1 = 0, L_S2 = 1, L_SI = 2, L_LAT = 3;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    logic [NUM_LANES-1:0] pins, lvl, rise;
    logic                 s1_high, s2_rise, lat_rise, si_bit;
    logic                 sync_unused;

    assign pins = {bus.LAT, bus.SPI_SI, bus.SCLK2, bus.SCLK1};

    pseudo_spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync [NUM_LANES-1:0] (
        .clk  (CLK),
        .rst  (RST),
        .din  (pins),
        .lvl  (lvl),
        .rise (rise)
    );

    assign s1_high     = lvl[L_S1];
    assign s2_rise     = rise[L_S2];
    assign si_bit      = lvl[L_SI];
    assign lat_rise    = rise[L_LAT];
    assign sync_unused = ^{rise[L_S1], rise[L_SI], lvl[L_S2], lvl[L_LAT]};

    state_t                       state, state_n;
    logic                         bgn_q, lat_pend;
    logic [MEMORY_ADDR_WIDTH-1:0] ptr;
    logic [RESERVED_DATA_LEN-1:0] len_q, byte_cnt_inc;
    logic [MEMORY_DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]                bit_cnt, bits_next;
    logic                         start, do_shift, set_err, load_wr, commit, lat_pend_set;
    logic                         byte_full;

    assign byte_cnt_inc = BYTE_CNT + 1'b1;
    assign byte_full    = (bit_cnt == BW'(MEMORY_DATA_WIDTH));
    assign bits_next    = bit_cnt + BW'(do_shift);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        start        = 1'b0;
        do_shift     = 1'b0;
        set_err      = 1'b0;
        load_wr      = 1'b0;
        commit       = 1'b0;
        lat_pend_set = 1'b0;
        case (state)
            IDLE: begin
                if (BGN && !bgn_q) begin
                    start   = 1'b1;
                    state_n = RECV;
                end
            end
            RECV: begin
                if (!BGN) begin
                    state_n = IDLE;
                end else if (byte_full) begin
                    load_wr      = 1'b1;
                    do_shift     = s2_rise;
                    set_err      = s2_rise & s1_high;
                    lat_pend_set = lat_rise;
                    state_n      = WRITE;
                end else begin
                    if (s2_rise) begin
                        // a zero-length frame takes no bits, so it can never write
                        if (len_q == '0) begin
                            set_err = 1'b1;
                        end else begin
                            do_shift = 1'b1;
                            set_err  = s1_high;
                        end
                    end
                    if (lat_rise) begin
                        if (bits_next == BW'(MEMORY_DATA_WIDTH)) begin
                            lat_pend_set = 1'b1;
                        end else begin
                            if (bits_next != '0 || BYTE_CNT < len_q) set_err = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
            end
            WRITE: begin
                commit   = 1'b1;
                do_shift = s2_rise;
                if (s2_rise && s1_high) set_err = 1'b1;
                if (!BGN) begin
                    state_n = IDLE;
                end else if (byte_cnt_inc == len_q) begin
                    if (s2_rise) set_err = 1'b1;
                    state_n = DONE;
                end else if (lat_pend || lat_rise) begin
                    set_err = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = RECV;
                end
            end
            DONE: begin
                if (s2_rise) set_err = 1'b1;
                if (!BGN)    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bgn_q    <= 1'b0;
            lat_pend <= 1'b0;
            ptr      <= '0;
            len_q    <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            BYTE_CNT <= '0;
            RX_ERR   <= 1'b0;
            bus.A    <= '0;
            bus.D    <= '0;
        end else begin
            bgn_q <= BGN;
            if (start) begin
                ptr      <= ADDR_BGN;
                len_q    <= DATA_LEN;
                shreg    <= '0;
                bit_cnt  <= '0;
                BYTE_CNT <= '0;
                RX_ERR   <= 1'b0;
                lat_pend <= 1'b0;
            end
            if (do_shift) shreg <= {shreg[MEMORY_DATA_WIDTH-2:0], si_bit};
            // a bit arriving while the byte is handed to D starts the next byte
            if (load_wr) begin
                bit_cnt <= BW'(do_shift);
                bus.A   <= ptr;
                bus.D   <= shreg;
            end else if (do_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (commit) begin
                ptr      <= ptr + 1'b1;
                BYTE_CNT <= byte_cnt_inc;
            end
            if (lat_pend_set) lat_pend <= 1'b1;
            if (set_err)      RX_ERR   <= 1'b1;
        end
    end

    assign bus.CEN = (state != WRITE);
    assign bus.WEN = (state != WRITE);
    assign RX_MUX  = (state != IDLE);
    assign RX_DONE = (state == DONE);
endmodule

// File: tb/tb_pseudo_spi_rx_sram_writer.sv
// Directed bench: serial frames in, SRAM writes checked by a scoreboard monitor.
module tb_pseudo_spi_rx_sram_writer;
    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BGN = 1'b0;
    logic [9:0] ADDR_BGN = '0;
    logic [7:0] DATA_LEN = '0;
    logic       RX_MUX, RX_DONE, RX_ERR;
    logic [7:0] BYTE_CNT;
    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];

    pseudo_spi_rx_sram_writer_if #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(10)) sif ();

    pseudo_spi_rx_sram_writer dut (
        .CLK      (CLK),
        .RST      (RST),
        .BGN      (BGN),
        .ADDR_BGN (ADDR_BGN),
        .DATA_LEN (DATA_LEN),
        .bus      (sif.master),
        .RX_MUX   (RX_MUX),
        .BYTE_CNT (BYTE_CNT),
        .RX_DONE  (RX_DONE),
        .RX_ERR   (RX_ERR)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every active SRAM cycle must match the head of the expected queue.
    always @(negedge CLK) begin
        if (!sif.CEN || !sif.WEN) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0h@%0h expected=none", sif.D, sif.A);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (sif.CEN !== 1'b0 || sif.WEN !== 1'b0 || sif.A !== e.a || sif.D !== e.d) begin
                    errors++;
                    $display("FAIL sram_write actual=%0h@%0h cen=%b wen=%b expected=%0h@%0h",
                             sif.D, sif.A, sif.CEN, sif.WEN, e.d, e.a);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic send_bit(input logic b, input logic overlap);
        sif.SPI_SI = b;
        sif.SCLK1  = 1'b1;
        cyc(3);
        if (!overlap) begin
            sif.SCLK1 = 1'b0;
            cyc(2);
        end
        sif.SCLK2 = 1'b1;
        cyc(4);
        sif.SCLK1 = 1'b0;
        sif.SCLK2 = 1'b0;
        cyc(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ovl_first);
        for (int i = 7; i >= 0; i--) send_bit(b[i], ovl_first && i == 7);
    endtask

    task automatic pulse_lat();
        sif.LAT = 1'b1;
        cyc(4);
        sif.LAT = 1'b0;
        cyc(4);
    endtask

    task automatic start_frame(input logic [9:0] a, input logic [7:0] len);
        BGN = 1'b0;
        cyc(2);
        ADDR_BGN = a;
        DATA_LEN = len;
        BGN      = 1'b1;
        cyc(2);
    endtask

    task automatic end_frame(input string name, input logic [7:0] cnt, input logic err);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (RX_DONE) seen = 1'b1;
            else cyc(1);
        end
        chk({name, "_rx_done"}, {31'd0, RX_DONE}, 32'd1);
        chk({name, "_rx_err"}, {31'd0, RX_ERR}, {31'd0, err});
        chk({name, "_byte_cnt"}, {24'd0, BYTE_CNT}, {24'd0, cnt});
        chk({name, "_pending_writes"}, exp_q.size(), 32'd0);
        BGN = 1'b0;
        cyc(2);
        chk({name, "_idle_mux"}, {31'd0, RX_MUX}, 32'd0);
        chk({name, "_idle_done"}, {31'd0, RX_DONE}, 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_cen_wen"}, {30'd0, sif.CEN, sif.WEN}, 32'd3);
        chk({name, "_a"}, {22'd0, sif.A}, 32'd0);
        chk({name, "_d"}, {24'd0, sif.D}, 32'd0);
        chk({name, "_status"}, {29'd0, RX_MUX, RX_DONE, RX_ERR}, 32'd0);
        chk({name, "_byte_cnt"}, {24'd0, BYTE_CNT}, 32'd0);
    endtask

    initial begin
        sif.SCLK1 = 1'b0; sif.SCLK2 = 1'b0; sif.LAT = 1'b0; sif.SPI_SI = 1'b0;
        cyc(3);
        RST = 1'b0;
        cyc(1);
        chk_reset_outputs("reset");

        // three bytes, frame completes on count
        start_frame(10'h100, 8'd3);
        expect_wr(10'h100, 8'hA5); expect_wr(10'h101, 8'h3C); expect_wr(10'h102, 8'hFF);
        send_byte(8'hA5, 1'b0); send_byte(8'h3C, 1'b0); send_byte(8'hFF, 1'b0);
        pulse_lat();
        end_frame("basic", 8'd3, 1'b0);

        // address wrap
        start_frame(10'h3FE, 8'd4);
        expect_wr(10'h3FE, 8'h01); expect_wr(10'h3FF, 8'h02);
        expect_wr(10'h000, 8'h03); expect_wr(10'h001, 8'h04);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        pulse_lat();
        end_frame("wrap", 8'd4, 1'b0);

        // short frame: one byte plus four bits
        start_frame(10'h040, 8'd2);
        expect_wr(10'h040, 8'hC3);
        send_byte(8'hC3, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        pulse_lat();
        end_frame("short", 8'd1, 1'b1);

        // overrun: second byte arrives in DONE
        start_frame(10'h080, 8'd1);
        expect_wr(10'h080, 8'h5A);
        send_byte(8'h5A, 1'b0); send_byte(8'h77, 1'b0);
        pulse_lat();
        end_frame("overrun", 8'd1, 1'b1);

        // zero length: bits are errors and nothing is written
        start_frame(10'h020, 8'd0);
        send_byte(8'hE7, 1'b0);
        pulse_lat();
        end_frame("zero_len", 8'd0, 1'b1);

        // reset mid-byte drops the frame
        start_frame(10'h050, 8'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        RST = 1'b1;
        BGN = 1'b0;
        cyc(1);
        RST = 1'b0;
        cyc(1);
        chk_reset_outputs("mid_reset");
        start_frame(10'h200, 8'd1);
        expect_wr(10'h200, 8'h81);
        send_byte(8'h81, 1'b0);
        end_frame("after_reset", 8'd1, 1'b0);

        // abort by dropping BGN mid-byte
        start_frame(10'h300, 8'd2);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("abort_busy_mux", {31'd0, RX_MUX}, 32'd1);
        BGN = 1'b0;
        cyc(1);
        chk("abort_mux", {31'd0, RX_MUX}, 32'd0);
        chk("abort_done", {31'd0, RX_DONE}, 32'd0);
        cyc(20);
        chk("abort_no_write", exp_q.size(), 32'd0);

        // SCLK1 still high across SCLK2 rise
        start_frame(10'h010, 8'd1);
        expect_wr(10'h010, 8'h96);
        send_byte(8'h96, 1'b1);
        end_frame("overlap", 8'd1, 1'b1);

        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
